// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: a 4-state FSM gates a prescaler and an m:ss BCD cascade.
// A registered display copy is frozen while a lap is held.
module stopwatch_ctrl #(
  parameter int PRESCALE = 100,
  parameter int PS_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clr,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       running,
  output logic       lap_held,
  output logic       tick,
  output logic       wrap
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] LAP   = 2'd3;

  logic [1:0]      state, state_nxt;
  logic [PS_W-1:0] ps, ps_nxt;
  logic [3:0]      so, st, mo;
  logic [3:0]      so_nxt, st_nxt, mo_nxt;
  logic            counting, step, zero, wrap_nxt, hold_disp;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start_stop) state_nxt = RUN;
      RUN:     if (start_stop) state_nxt = PAUSE;
               else if (lap)   state_nxt = LAP;
      LAP:     if (start_stop) state_nxt = PAUSE;
               else if (lap)   state_nxt = RUN;
      PAUSE:   if (clr)        state_nxt = IDLE;
               else if (start_stop) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign counting  = (state == RUN) || (state == LAP);
  assign step      = counting && (ps == PS_W'(PRESCALE - 1));
  assign zero      = (state == PAUSE) && clr;
  // The display stays frozen only while remaining in LAP; entering LAP captures the new count.
  assign hold_disp = (state == LAP) && (state_nxt == LAP);

  always_comb begin
    ps_nxt   = ps;
    so_nxt   = so;
    st_nxt   = st;
    mo_nxt   = mo;
    wrap_nxt = 1'b0;
    if (zero) begin
      ps_nxt = '0;
      so_nxt = '0;
      st_nxt = '0;
      mo_nxt = '0;
    end else if (step) begin
      ps_nxt = '0;
      if (so == 4'd9) begin
        so_nxt = '0;
        if (st == 4'd5) begin
          st_nxt = '0;
          if (mo == 4'd9) begin
            mo_nxt   = '0;
            wrap_nxt = 1'b1;
          end else begin
            mo_nxt = mo + 4'd1;
          end
        end else begin
          st_nxt = st + 4'd1;
        end
      end else begin
        so_nxt = so + 4'd1;
      end
    end else if (counting) begin
      ps_nxt = ps + PS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ps       <= '0;
      so       <= '0;
      st       <= '0;
      mo       <= '0;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      running  <= 1'b0;
      lap_held <= 1'b0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      ps       <= ps_nxt;
      so       <= so_nxt;
      st       <= st_nxt;
      mo       <= mo_nxt;
      running  <= (state_nxt == RUN) || (state_nxt == LAP);
      lap_held <= (state_nxt == LAP);
      tick     <= step;
      wrap     <= wrap_nxt;
      if (!hold_disp) begin
        sec_ones <= so_nxt;
        sec_tens <= st_nxt;
        min_ones <= mo_nxt;
      end
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Controller that sequences a prescaled BCD time counter as a stopwatch. It covers digits m:ss from 0:00 to 9:59. Start/stop, clear and lap pulses drive a 4-state FSM that gates a clock-divider prescaler and a three-digit BCD cascade. It sits between debounced button pulses and the 7-segment display driver.

Parameters:
PRESCALE, 100, clk cycles per count step; legal range 2..256.
PS_W, 8, prescaler register width; must satisfy 2^PS_W >= PRESCALE.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
start_stop  input  1  single-cycle pulse; toggles between run and pause.
clr  input  1  single-cycle pulse; zeroes the count, honoured only in PAUSE.
lap  input  1  single-cycle pulse; freezes or releases the display while counting continues.
sec_ones  output  4  displayed seconds units, BCD 0..9.
sec_tens  output  4  displayed seconds tens, BCD 0..5.
min_ones  output  4  displayed minutes, BCD 0..9.
running  output  1  high in RUN and LAP.
lap_held  output  1  high in LAP.
tick  output  1  one-cycle pulse on every count step.
wrap  output  1  one-cycle pulse when the count steps from 9:59 to 0:00.

Behaviour:
- Reset (async, rst=1): state=IDLE, prescaler=0, internal count=0:00, all outputs 0. Reset asserted mid-count aborts immediately, with no residual tick or wrap.
- All outputs are registered.
- FSM states: IDLE, RUN, PAUSE, LAP. Inputs are sampled on the rising clk edge.
- IDLE: start_stop -> RUN. clr and lap are ignored.
- RUN: start_stop -> PAUSE. Else lap -> LAP; the display captures the count value present after that edge.
- LAP: start_stop -> PAUSE, and the display returns to the live count. Else lap -> RUN, and the display returns to the live count. Counting never stops in LAP.
- PAUSE: clr -> IDLE, zeroing the prescaler and count. Else start_stop -> RUN. lap is ignored.
- Simultaneous pulses: in PAUSE, clr beats start_stop. In RUN/LAP, start_stop beats lap. clr is ignored outside PAUSE.
- Prescaler counts only in RUN and LAP:
  - It increments on each edge while in RUN/LAP, i.e. starting the edge after the start_stop edge.
  - At PRESCALE-1 it reloads to 0 and generates a step.
  - PAUSE holds the prescaler value, so a resumed count completes the remaining cycles rather than restarting.
- Step carry cascade, applied on the step edge:
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_ones.
  - min_ones 9->0 asserts wrap. Counting continues from 0:00.
- tick is high for exactly the cycle in which the new count is visible internally, in RUN or LAP.
- wrap coincides with the tick of the 9:59->0:00 step.
- Display outputs:
  - Equal the internal count in IDLE, RUN and PAUSE.
  - In LAP they hold the captured value.
  - On leaving LAP they show the live count from the leaving edge onward.
- A step occurring on the same edge as a start_stop into PAUSE is still applied. The pause takes effect for subsequent edges.
- Start timing: with start_stop sampled at edge k, the first step occurs at edge k+PRESCALE.
- Digit values are never outside their BCD ranges.

Test Plan:
1. PRESCALE=4. Reset, start_stop pulse at edge 0 -> tick at edges 4, 8, 12; sec_ones = 1, 2, 3; running=1.
2. Run to 9:59, then one more step -> outputs 0:00, wrap=1 for exactly one cycle coinciding with tick; counting continues (0:01 four edges later).
3. Run to 0:07 with prescaler=2, pause for 10 cycles, resume -> 0:08 exactly 2 edges after resume (prescaler held); no tick while paused.
4. Running at 0:12: lap -> display holds 0:12 for 20 cycles while ticks continue. Second lap -> display shows 0:17 immediately; lap_held returns to 0.
5. clr while RUN -> ignored. start_stop then clr -> 0:00, IDLE, running=0. clr+start_stop in the same PAUSE cycle -> IDLE.
6. rst pulse mid-count at 3:41 in LAP -> all outputs 0 asynchronously, state IDLE; a subsequent start_stop restarts from 0:00 with a full PRESCALE interval.
